// File: rtl/rv32i_pkg.sv
// Shared rv32i types and widths for the instruction fetch stage.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    FAULT
  } fetch_state_e;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Sequential fetch address; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pcNext(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush, count and full/empty flags.
// Holds decoded-side fetch entries or the PCs of in-flight requests.
module fetch_queue
  import rv32i_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  T                           i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output T                           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          w_doPush;
  logic          w_doPop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == CW'(DEPTH));
  assign o_count  = r_count;
  assign o_data   = r_mem[r_rdPtr];
  assign w_doPop  = i_pop && !o_empty;
  // A push into a full queue is accepted only when a pop frees the slot in the same cycle.
  assign w_doPush = i_push && (!o_full || w_doPop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= i_data;
        r_wrPtr        <= bump(r_wrPtr);
      end
      if (w_doPop) begin
        r_rdPtr <= bump(r_rdPtr);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rv32i instruction fetch: PC, credit-limited imem requests, stale-response dropping, decode queue.
// Optional feature macro FETCH_ALIGN_CHECK_EN: misaligned redirects trap into FAULT (adds fetch_fault ports).
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [ILEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic            fetch_fault,
  output logic [XLEN-1:0] fetch_fault_pc
`endif
);

  localparam int CW = $clog2(QDEPTH + 1);

  fetch_state_e    r_state;
  fetch_state_e    w_nextState;
  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_dropCnt;
  logic            r_reqValid;

  logic [CW-1:0]   w_inflight;
  logic [CW-1:0]   w_qCount;
  logic            w_qEmpty;
  logic            w_qFull;
  logic            w_pcqFull;
  logic            w_pcqEmpty;
  fetch_entry_t    w_qHead;
  fetch_entry_t    w_pushEntry;
  logic [XLEN-1:0] w_pcqHead;
  logic            w_reqHs;
  logic            w_decHs;
  logic            w_rspPush;
  logic            w_qPop;
  logic            w_misaligned;
  logic [XLEN-1:0] w_redirPc;
  logic [CW:0]     w_nextInflight;
  logic [CW:0]     w_nextQCount;
  logic            w_reqValidNext;
  logic            w_unused;

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign w_redirPc    = redirect_pc;
`else
  assign w_misaligned = 1'b0;
  assign w_redirPc    = {redirect_pc[XLEN-1:2], 2'b00};
`endif

  assign w_reqHs     = r_reqValid && imem_req_ready;
  assign w_decHs     = dec_valid && dec_ready;
  // A redirect invalidates any response in its cycle as well as the queue contents.
  assign w_rspPush   = imem_rsp_valid && (r_dropCnt == '0) && !redirect_valid;
  assign w_qPop      = w_decHs && !redirect_valid;
  assign w_pushEntry = '{instr: imem_rsp_data, pc: w_pcqHead};

  assign w_nextInflight = {1'b0, w_inflight} + (CW+1)'(w_reqHs) - (CW+1)'(imem_rsp_valid);

  always_comb begin
    w_nextState  = r_state;
    w_nextQCount = '0;
    if (!redirect_valid) begin
      w_nextQCount = {1'b0, w_qCount} + (CW+1)'(w_rspPush) - (CW+1)'(w_qPop);
    end
    if (redirect_valid) begin
      if (w_misaligned) begin
        w_nextState = FAULT;
      end else if (w_nextInflight != '0) begin
        w_nextState = DRAIN;
      end else begin
        w_nextState = RUN;
      end
    end else if ((r_state == DRAIN) &&
                 ((r_dropCnt == '0) || (imem_rsp_valid && (r_dropCnt == CW'(1))))) begin
      w_nextState = RUN;
    end
  end

  // Request valid is registered from next-cycle credit so it is low throughout reset.
  assign w_reqValidNext = (w_nextState == RUN) &&
                          (({1'b0, w_nextInflight} + {1'b0, w_nextQCount}) < (CW+2)'(QDEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_pc       <= RESET_PC;
      r_dropCnt  <= '0;
      r_reqValid <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_reqValid <= w_reqValidNext;
      if (redirect_valid) begin
        r_dropCnt <= w_nextInflight[CW-1:0];
      end else if (imem_rsp_valid && (r_dropCnt != '0)) begin
        r_dropCnt <= r_dropCnt - CW'(1);
      end
      if (redirect_valid && !w_misaligned) begin
        r_pc <= w_redirPc;
      end else if (w_reqHs) begin
        r_pc <= pcNext(r_pc);
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic            r_fault;
  logic [XLEN-1:0] r_faultPc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault   <= 1'b0;
      r_faultPc <= '0;
    end else if (redirect_valid) begin
      r_fault   <= w_misaligned;
      r_faultPc <= w_misaligned ? redirect_pc : '0;
    end
  end

  assign fetch_fault    = r_fault;
  assign fetch_fault_pc = r_faultPc;
`endif

  // Every issued request leaves its PC here; responses, dropped or not, pop in order.
  fetch_queue #(
    .DEPTH (QDEPTH),
    .T     (logic [XLEN-1:0])
  ) u_pcQueue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_reqHs),
    .i_data  (r_pc),
    .i_pop   (imem_rsp_valid),
    .i_flush (1'b0),
    .o_data  (w_pcqHead),
    .o_count (w_inflight),
    .o_full  (w_pcqFull),
    .o_empty (w_pcqEmpty)
  );

  fetch_queue #(
    .DEPTH (QDEPTH),
    .T     (fetch_entry_t)
  ) u_instrQueue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_rspPush),
    .i_data  (w_pushEntry),
    .i_pop   (w_qPop),
    .i_flush (redirect_valid),
    .o_data  (w_qHead),
    .o_count (w_qCount),
    .o_full  (w_qFull),
    .o_empty (w_qEmpty)
  );

  assign imem_req_valid = r_reqValid;
  assign imem_req_addr  = r_pc;
  assign dec_valid      = !w_qEmpty;
  assign dec_instr      = w_qEmpty ? '0 : w_qHead.instr;
  assign dec_pc         = w_qEmpty ? '0 : w_qHead.pc;

  assign w_unused = ^{w_qFull, w_pcqFull, w_pcqEmpty, redirect_pc[1:0]};

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order latency-configurable instruction memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b1;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_fault;
  logic [31:0] fetch_fault_pc;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat = 1;
  int reqCount = 0;
  logic [31:0] pendAddr[$];
  int          pendDue[$];

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .QDEPTH   (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_fault    (fetch_fault),
    .fetch_fault_pc (fetch_fault_pc)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: memory answers in order after lat cycles; redirect is a one-cycle pulse.
  task automatic applyStimulus();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (pendAddr.size() > 0 && pendDue[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instrOf(pendAddr[0]);
      void'(pendAddr.pop_front());
      void'(pendDue.pop_front());
    end
    if (imem_req_valid && imem_req_ready) begin
      pendAddr.push_back(imem_req_addr);
      pendDue.push_back(cyc + lat);
      reqCount++;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    redirect_valid = 1'b0;
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    rst_n          = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_ready      = 1'b1;
    imem_req_ready = 1'b1;
    pendAddr.delete();
    pendDue.delete();
    #1;
    checkOutput({tag, " req_valid"}, {31'b0, imem_req_valid}, 32'd0);
    checkOutput({tag, " dec_valid"}, {31'b0, dec_valid}, 32'd0);
    checkOutput({tag, " dec_instr"}, dec_instr, 32'd0);
    checkOutput({tag, " dec_pc"}, dec_pc, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    checkOutput({tag, " fetch_fault"}, {31'b0, fetch_fault}, 32'd0);
`endif
    @(negedge clk);
    rst_n    = 1'b1;
    cyc      = 0;
    reqCount = 0;
  endtask

  task automatic waitDec(input string tag, input logic [31:0] expPc);
    int n = 0;
    while (!dec_valid && n < 20) begin
      applyStimulus();
      n++;
    end
    checkOutput({tag, " dec_valid"}, {31'b0, dec_valid}, 32'd1);
    checkOutput({tag, " dec_pc"}, dec_pc, expPc);
    checkOutput({tag, " dec_instr"}, dec_instr, instrOf(expPc));
    applyStimulus();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Sequential fetch with 1-cycle memory, decode always ready.
    lat = 1;
    doReset("t1 reset");
    applyStimulus();
    checkOutput("t1 c1 req_valid", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("t1 c1 addr", imem_req_addr, 32'h0);
    applyStimulus();
    checkOutput("t1 c2 addr", imem_req_addr, 32'h4);
    applyStimulus();
    checkOutput("t1 c3 dec_valid", {31'b0, dec_valid}, 32'd1);
    checkOutput("t1 c3 dec_pc", dec_pc, 32'h0);
    checkOutput("t1 c3 dec_instr", dec_instr, instrOf(32'h0));
    applyStimulus();
    checkOutput("t1 c4 addr", imem_req_addr, 32'h8);
    checkOutput("t1 c4 dec_pc", dec_pc, 32'h4);
    applyStimulus();
    waitDec("t1 pc8", 32'h8);
    waitDec("t1 pcC", 32'hC);

    // Decode stalled: credit limits accepted requests to QDEPTH, none lost on release.
    doReset("t2 reset");
    dec_ready = 1'b0;
    for (int i = 0; i < 12; i++) applyStimulus();
    checkOutput("t2 reqCount", reqCount, 32'd2);
    checkOutput("t2 req_valid", {31'b0, imem_req_valid}, 32'd0);
    checkOutput("t2 dec_pc", dec_pc, 32'h0);
    dec_ready = 1'b1;
    waitDec("t2 pc0", 32'h0);
    waitDec("t2 pc4", 32'h4);
    waitDec("t2 pc8", 32'h8);
    waitDec("t2 pcC", 32'hC);
    dec_ready = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus();
    checkOutput("t2 prefill dec_valid", {31'b0, dec_valid}, 32'd1);
    doReset("t2 midrst");

    // Two in flight when redirected: both responses dropped while draining.
    lat = 3;
    doReset("t3 reset");
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("t3 c3 req_valid", {31'b0, imem_req_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    applyStimulus();
    checkOutput("t3 c4 req_valid", {31'b0, imem_req_valid}, 32'd0);
    checkOutput("t3 c4 dec_valid", {31'b0, dec_valid}, 32'd0);
    applyStimulus();
    checkOutput("t3 c5 req_valid", {31'b0, imem_req_valid}, 32'd0);
    applyStimulus();
    checkOutput("t3 c6 req_valid", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("t3 c6 addr", imem_req_addr, 32'h100);
    waitDec("t3 pc100", 32'h100);
    waitDec("t3 pc104", 32'h104);

    // Redirect coinciding with a response and a decode handshake.
    lat = 1;
    doReset("t4 reset");
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("t4 c3 dec_pc", dec_pc, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    applyStimulus();
    checkOutput("t4 c4 dec_valid", {31'b0, dec_valid}, 32'd0);
    checkOutput("t4 c4 req_valid", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("t4 c4 addr", imem_req_addr, 32'h200);
    waitDec("t4 pc200", 32'h200);

    // PC wraps at the top of the address space.
    doReset("t5 reset");
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    applyStimulus();
    checkOutput("t5 c1 addr", imem_req_addr, 32'hFFFF_FFFC);
    applyStimulus();
    checkOutput("t5 c2 addr", imem_req_addr, 32'h0);
    waitDec("t5 pcTop", 32'hFFFF_FFFC);
    waitDec("t5 pc0", 32'h0);

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned redirect traps; an aligned redirect clears the fault and resumes.
    doReset("t6 reset");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    applyStimulus();
    checkOutput("t6 fault", {31'b0, fetch_fault}, 32'd1);
    checkOutput("t6 fault_pc", fetch_fault_pc, 32'h102);
    checkOutput("t6 req_valid", {31'b0, imem_req_valid}, 32'd0);
    applyStimulus();
    applyStimulus();
    checkOutput("t6 held req_valid", {31'b0, imem_req_valid}, 32'd0);
    checkOutput("t6 held dec_valid", {31'b0, dec_valid}, 32'd0);
    checkOutput("t6 held fault", {31'b0, fetch_fault}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    applyStimulus();
    checkOutput("t6 cleared fault", {31'b0, fetch_fault}, 32'd0);
    checkOutput("t6 cleared fault_pc", fetch_fault_pc, 32'h0);
    checkOutput("t6 resume addr", imem_req_addr, 32'h200);
    waitDec("t6 pc200", 32'h200);
`else
    // Without the alignment check the low target bits are ignored.
    doReset("t6 reset");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    applyStimulus();
    checkOutput("t6 req_valid", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("t6 aligned addr", imem_req_addr, 32'h100);
    waitDec("t6 pc100", 32'h100);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
